clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_ctrl.sv | 108 ++++++++++
 tb/tb_clkdiv_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: two-requester arbiter and sequencer for a programmable clock
// divider (output = clk / 2^div). A granted request is written to the divider
// with a one-cycle wr strobe, the controller waits 2^div cycles for the new
// divider setting to settle, then pulses ack for the served requester.
// Requests for the value already programmed skip the write and settle phases.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - synchronous active-low reset
//   req       - per-requester change request (bit i = requester i)
//   div_req0  - divide select from requester 0, stable while req[0]=1
//   div_req1  - divide select from requester 1, stable while req[1]=1
//   ack       - one-cycle completion pulse per requester
//   busy      - high whenever a transaction is in progress
//   wr        - one-cycle write strobe to the divider
//   div_out   - committed divide select driving the divider
//   grant     - index of the requester being served (valid while busy)
module clkdiv_ctrl #(
  parameter int unsigned CLK_DIV_SIZE = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  input  logic [CLK_DIV_SIZE-1:0] div_req0,
  input  logic [CLK_DIV_SIZE-1:0] div_req1,
  output logic [1:0]              ack,
  output logic                    busy,
  output logic                    wr,
  output logic [CLK_DIV_SIZE-1:0] div_out,
  output logic                    grant
);

  // Wide enough to hold 2^(2^CLK_DIV_SIZE - 1) without wrapping.
  localparam int unsigned CntW = 2**CLK_DIV_SIZE + 1;

  typedef enum logic [1:0] {StIdle, StWrite, StSettle, StAck} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [CLK_DIV_SIZE-1:0] pending_q;
  logic                    last_q;     // requester served most recently

  logic                    sel;
  logic [CLK_DIV_SIZE-1:0] sel_div;
  logic [CntW-1:0]         settle_len;

  always_comb begin
    // Round-robin: on contention the requester not served last wins.
    sel        = (req == 2'b11) ? ~last_q : req[1];
    sel_div    = sel ? div_req1 : div_req0;
    settle_len = CntW'(1) << pending_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= '0;
      last_q    <= 1'b1;  // makes requester 0 the first winner
      ack       <= 2'b00;
      busy      <= 1'b0;
      wr        <= 1'b0;
      div_out   <= '0;
      grant     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|req) begin
            grant     <= sel;
            last_q    <= sel;
            pending_q <= sel_div;
            busy      <= 1'b1;
            if (sel_div == div_out) begin
              // Divider already runs at this ratio: acknowledge straight away.
              state_q <= StAck;
              ack     <= sel ? 2'b10 : 2'b01;
            end else begin
              state_q <= StWrite;
              wr      <= 1'b1;
              div_out <= sel_div;
            end
          end
        end
        StWrite: begin
          wr      <= 1'b0;
          cnt_q   <= '0;
          state_q <= StSettle;
        end
        StSettle: begin
          cnt_q <= cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == settle_len) begin
            state_q <= StAck;
            ack     <= {grant, ~grant};
          end
        end
        StAck: begin
          ack     <= 2'b00;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a transaction-timeline model of the controller.
module tb_clkdiv_ctrl;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] div_req0;
  logic [W-1:0] div_req1;
  logic [1:0]   ack;
  logic         busy;
  logic         wr;
  logic [W-1:0] div_out;
  logic         grant;

  always #5 clk = ~clk;

  clkdiv_ctrl #(.CLK_DIV_SIZE(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .div_req0 (div_req0),
    .div_req1 (div_req1),
    .ack      (ack),
    .busy     (busy),
    .wr       (wr),
    .div_out  (div_out),
    .grant    (grant)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: a transaction occupies cycles 1..m_total after its accepting edge.
  int           m_t;
  int           m_total;
  bit           m_wr;
  logic [W-1:0] m_div;
  logic         m_last;
  logic         m_grant;
  bit           m_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic         w;
    logic [W-1:0] d;
    logic [1:0]   exp_ack;
    @(posedge clk);
    if (!rst_n) begin
      m_t = 0; m_total = 0; m_wr = 0; m_div = '0; m_last = 1'b1; m_grant = 1'b0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (m_t == 0) begin
        if (req != 2'b00) begin
          w       = (req == 2'b11) ? ~m_last : req[1];
          d       = w ? div_req1 : div_req0;
          m_grant = w;
          m_last  = w;
          m_wr    = (d != m_div);
          m_total = m_wr ? 2 + (1 << d) : 1;
          m_div   = d;
          m_t     = 1;
        end
      end else begin
        m_t++;
        if (m_t > m_total) m_t = 0;
      end
    end
    #1;
    exp_ack = (m_t != 0 && m_t == m_total) ? (m_grant ? 2'b10 : 2'b01) : 2'b00;
    chk("busy", busy, 32'(m_t != 0));
    chk("wr", wr, 32'(m_wr && m_t == 1));
    chk("ack", ack, exp_ack);
    chk("div_out", div_out, m_div);
    chk("ack_onehot", 32'($countones(ack) <= 1), 1);
    if (m_t != 0 || m_rst) chk("grant", grant, m_grant);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    m_t = 0; m_total = 0; m_wr = 0; m_div = '0; m_last = 1'b1; m_grant = 1'b0; m_rst = 0;
    rst_n = 1'b0; req = 2'b00; div_req0 = '0; div_req1 = '0;
    run(2);
    chk("reset_busy", busy, 0);
    chk("reset_div_out", div_out, 0);
    rst_n = 1'b1;
    run(2);

    // Single request, div 3: wr next cycle, 8 settle cycles, ack on cycle 10.
    div_req0 = 3'd3; req = 2'b01;
    step();
    req = 2'b00;
    chk("d3_wr", wr, 1);
    chk("d3_div_out", div_out, 3);
    run(8);
    chk("d3_no_early_ack", ack, 0);
    step();
    chk("d3_ack", ack, 2'b01);
    step();
    chk("d3_idle", busy, 0);

    // Both requesting: requester 0 first, then requester 1.
    div_req0 = 3'd2; div_req1 = 3'd5; req = 2'b11;
    run(45);
    req = 2'b00;
    run(50);

    // Same value already programmed: no write, ack one cycle after sampling.
    div_req0 = 3'd4; req = 2'b01;
    step();
    req = 2'b00;
    run(20);
    div_req1 = 3'd4; req = 2'b10;
    step();
    req = 2'b00;
    chk("skip_wr", wr, 0);
    chk("skip_ack", ack, 2'b10);
    chk("skip_busy", busy, 1);
    step();
    chk("skip_done", busy, 0);

    // Reset in the middle of a long settle aborts without ack.
    div_req0 = 3'd7; req = 2'b01;
    step();
    req = 2'b00;
    run(60);
    rst_n = 1'b0;
    step();
    chk("abort_div_out", div_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    rst_n = 1'b1;
    div_req1 = 3'd1; req = 2'b10;
    step();
    req = 2'b00;
    run(10);

    // Extremes of the settle range.
    div_req0 = 3'd0; req = 2'b01;
    step();
    req = 2'b00;
    run(6);
    div_req0 = 3'd7; req = 2'b01;
    step();
    req = 2'b00;
    run(140);

    // Both held continuously: grants alternate.
    div_req0 = 3'd1; div_req1 = 3'd2; req = 2'b11;
    run(60);
    req = 2'b00;
    run(10);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (!req[0]) begin
        if ($urandom_range(0, 3) == 0) begin
          div_req0 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom_range(0, 2));
          req[0] = 1'b1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        req[0] = 1'b0;
      end
      if (!req[1]) begin
        if ($urandom_range(0, 3) == 0) begin
          div_req1 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom_range(0, 2));
          req[1] = 1'b1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        req[1] = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
